// File: rtl/adc_cmd_sequencer.sv
// adc_cmd_sequencer: queues 24-bit ADC serial-interface writes and sequences the
// ADC control channel codes (0xFF reset, 0x00 idle, 0x01 buffer, 0x02 issue).
// Ports: adc_clkinp/iStateReset (sync, active-high); iCmdData/iCmdWrite enqueue;
//   iGo starts a drain, iHwReset requests a reset pulse first, iClrErr clears
//   oOverflow; oControlComm/oSerialCmd drive the ADC control module; oCmdCount,
//   oCmdFull, oBusy, oDone (1-cycle pulse) and oOverflow (sticky) are status.
// Optional: define ADC_CMD_SEQ_AUTOSYNC_EN to insert a 0x04 SYNC code (BUF_HOLD
//   cycles, then 0x00 for GAP_HOLD) before completion of any non-empty run.
module adc_cmd_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int RESET_HOLD = 256,
  parameter int BUF_HOLD   = 128,
  parameter int ISSUE_HOLD = 1024,
  parameter int GAP_HOLD   = 128
) (
  input  logic                          adc_clkinp,
  input  logic                          iStateReset,
  input  logic [23:0]                   iCmdData,
  input  logic                          iCmdWrite,
  input  logic                          iGo,
  input  logic                          iHwReset,
  input  logic                          iClrErr,
  output logic [7:0]                    oControlComm,
  output logic [23:0]                   oSerialCmd,
  output logic [$clog2(FIFO_DEPTH):0]   oCmdCount,
  output logic                          oCmdFull,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oOverflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // A hold of 0 would never let the down-counter expire cleanly; clamp to 1.
  localparam logic [31:0] RST_H = (RESET_HOLD < 1) ? 32'd1 : 32'(RESET_HOLD);
  localparam logic [31:0] BUF_H = (BUF_HOLD   < 1) ? 32'd1 : 32'(BUF_HOLD);
  localparam logic [31:0] ISS_H = (ISSUE_HOLD < 1) ? 32'd1 : 32'(ISSUE_HOLD);
  localparam logic [31:0] GAP_H = (GAP_HOLD   < 1) ? 32'd1 : 32'(GAP_HOLD);

  typedef enum logic [3:0] {
    IDLE, HWRST, HWGAP, LOAD, ISSUE, GAP, FINISH
`ifdef ADC_CMD_SEQ_AUTOSYNC_EN
    , SYNC, SYNC_GAP
`endif
  } state_t;

`ifdef ADC_CMD_SEQ_AUTOSYNC_EN
  localparam state_t END_STATE = SYNC;
`else
  localparam state_t END_STATE = FINISH;
`endif

  state_t        state, state_nxt;
  logic [31:0]   hold_cnt;
  logic          pop;
  logic          hw_pend;
  logic          idle_done;

  // ---------------- command FIFO (first-word fall-through) ----------------
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_wr, do_pop;

  assign full   = (count == DEPTH_C);
  assign do_wr  = iCmdWrite & ~full;
  assign do_pop = pop & (count != '0);

  always_ff @(posedge adc_clkinp) begin
    if (do_wr) mem[wr_ptr] <= iCmdData;
  end

  always_ff @(posedge adc_clkinp) begin
    if (iStateReset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped write in the same cycle as a clear still leaves the flag set.
      oOverflow <= (oOverflow & ~iClrErr) | (iCmdWrite & full);
    end
  end

  // ---------------- sequencer FSM ----------------
  function automatic logic [31:0] hold_of(input state_t s);
    case (s)
      HWRST:    hold_of = RST_H;
      LOAD:     hold_of = BUF_H;
      ISSUE:    hold_of = ISS_H;
      HWGAP:    hold_of = GAP_H;
      GAP:      hold_of = GAP_H;
`ifdef ADC_CMD_SEQ_AUTOSYNC_EN
      SYNC:     hold_of = BUF_H;
      SYNC_GAP: hold_of = GAP_H;
`endif
      default:  hold_of = 32'd1;
    endcase
  endfunction

  logic hw_req, last;
  // A reset request arriving in the same cycle as iGo must still be honoured.
  assign hw_req = hw_pend | iHwReset;
  assign last   = (hold_cnt == 32'd0);

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    oControlComm = 8'h00;
    case (state)
      IDLE: begin
        if (iGo) begin
          if (hw_req) state_nxt = HWRST;
          else if (count != '0) begin
            state_nxt = LOAD;
            pop       = 1'b1;
          end
        end
      end
      HWRST: begin
        oControlComm = 8'hFF;
        if (last) state_nxt = HWGAP;
      end
      HWGAP, GAP: begin
        if (last) begin
          if (count != '0) begin
            state_nxt = LOAD;
            pop       = 1'b1;
          end else begin
            state_nxt = END_STATE;
          end
        end
      end
      LOAD: begin
        oControlComm = 8'h01;
        if (last) state_nxt = ISSUE;
      end
      ISSUE: begin
        oControlComm = 8'h02;
        if (last) state_nxt = GAP;
      end
`ifdef ADC_CMD_SEQ_AUTOSYNC_EN
      SYNC: begin
        oControlComm = 8'h04;
        if (last) state_nxt = SYNC_GAP;
      end
      SYNC_GAP: begin
        if (last) state_nxt = FINISH;
      end
`endif
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge adc_clkinp) begin
    if (iStateReset) begin
      state      <= IDLE;
      hold_cnt   <= 32'd0;
      oSerialCmd <= 24'd0;
      hw_pend    <= 1'b0;
      idle_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Every state change reloads the single down-counter for the new state.
      if (state_nxt != state)  hold_cnt <= hold_of(state_nxt) - 32'd1;
      else if (hold_cnt != 0)  hold_cnt <= hold_cnt - 32'd1;
      // Popped word is latched on LOAD entry and held through LOAD+ISSUE.
      if (do_pop) oSerialCmd <= mem[rd_ptr];
      if (iHwReset)            hw_pend <= 1'b1;
      else if (state == HWRST) hw_pend <= 1'b0;
      // Empty run: report completion without leaving IDLE.
      idle_done <= (state == IDLE) & iGo & ~hw_req & (count == '0);
    end
  end

  assign oCmdCount = count;
  assign oCmdFull  = full;
  assign oBusy     = (state != IDLE);
  assign oDone     = (state == FINISH) | idle_done;

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
module tb_adc_cmd_sequencer;

  logic        adc_clkinp = 1'b0;
  logic        iStateReset, iCmdWrite, iGo, iHwReset, iClrErr;
  logic [23:0] iCmdData;
  logic [7:0]  oControlComm;
  logic [23:0] oSerialCmd;
  logic [4:0]  oCmdCount;
  logic        oCmdFull, oBusy, oDone, oOverflow;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  adc_cmd_sequencer dut (
    .adc_clkinp   (adc_clkinp),
    .iStateReset  (iStateReset),
    .iCmdData     (iCmdData),
    .iCmdWrite    (iCmdWrite),
    .iGo          (iGo),
    .iHwReset     (iHwReset),
    .iClrErr      (iClrErr),
    .oControlComm (oControlComm),
    .oSerialCmd   (oSerialCmd),
    .oCmdCount    (oCmdCount),
    .oCmdFull     (oCmdFull),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oOverflow    (oOverflow)
  );

  always #5 adc_clkinp = ~adc_clkinp;

  task automatic step();
    @(posedge adc_clkinp);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect `code` on the control channel for exactly `len` cycles with no oDone,
  // optionally with a fixed serial word.
  task automatic seg(input string tag, input logic [7:0] code, input int len,
                     input logic chk_ser, input logic [23:0] ser);
    int good = 0;
    for (int i = 0; i < len; i++) begin
      if (oControlComm === code && oDone === 1'b0 && (!chk_ser || oSerialCmd === ser))
        good++;
      step();
    end
    check(tag, 32'(good), 32'(len));
  endtask

  task automatic wr(input logic [23:0] d);
    iCmdData  = d;
    iCmdWrite = 1'b1;
    step();
    iCmdWrite = 1'b0;
  endtask

  task automatic go(input logic hw);
    iGo      = 1'b1;
    iHwReset = hw;
    step();
    iGo      = 1'b0;
    iHwReset = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic [23:0] w);
    seg({tag, "_buf"},   8'h01, 128,  1'b1, w);
    seg({tag, "_issue"}, 8'h02, 1024, 1'b1, w);
    seg({tag, "_gap"},   8'h00, 128,  1'b0, 24'd0);
  endtask

  task automatic tail(input string tag);
`ifdef ADC_CMD_SEQ_AUTOSYNC_EN
    seg({tag, "_sync"},    8'h04, 128, 1'b0, 24'd0);
    seg({tag, "_syncgap"}, 8'h00, 128, 1'b0, 24'd0);
`endif
    check({tag, "_done"}, 32'(oDone), 1);
    check({tag, "_done_comm"}, 32'(oControlComm), 0);
    step();
    check({tag, "_done_clr"}, 32'(oDone), 0);
    check({tag, "_idle"}, 32'(oBusy), 0);
  endtask

  initial begin
    iStateReset = 1'b1;
    iCmdWrite = 1'b0; iGo = 1'b0; iHwReset = 1'b0; iClrErr = 1'b0;
    iCmdData = 24'd0;
    step();
    step();
    iStateReset = 1'b0;
    check("rst_comm",  32'(oControlComm), 0);
    check("rst_ser",   32'(oSerialCmd), 0);
    check("rst_count", 32'(oCmdCount), 0);
    check("rst_full",  32'(oCmdFull), 0);
    check("rst_busy",  32'(oBusy), 0);
    check("rst_done",  32'(oDone), 0);
    check("rst_ovf",   32'(oOverflow), 0);

    // Reset flushes queued entries; a following iGo is an empty run.
    wr(24'h000001); wr(24'h000002); wr(24'h000003);
    check("q3_count", 32'(oCmdCount), 3);
    iStateReset = 1'b1;
    step();
    iStateReset = 1'b0;
    check("flush_count", 32'(oCmdCount), 0);
    check("flush_comm",  32'(oControlComm), 0);
    check("flush_busy",  32'(oBusy), 0);
    go(1'b0);
    check("empty_done", 32'(oDone), 1);
    check("empty_busy", 32'(oBusy), 0);
    step();
    check("empty_done_clr", 32'(oDone), 0);
    seg("empty_quiet", 8'h00, 50, 1'b0, 24'd0);

    // Single command, no hardware reset: LOAD one cycle after iGo.
    wr(24'h0A1234);
    go(1'b0);
    cmd("single", 24'h0A1234);
    tail("single");

    // Hardware reset requested with iGo, then two commands in FIFO order.
    wr(24'h111111);
    wr(24'h222222);
    go(1'b1);
    seg("hw_reset", 8'hFF, 256, 1'b0, 24'd0);
    seg("hw_gap",   8'h00, 128, 1'b0, 24'd0);
    cmd("hw_a", 24'h111111);
    cmd("hw_b", 24'h222222);
    tail("hw");

    // Fill to depth, overflow on the 17th write, clear, drain exactly 16.
    for (int i = 0; i < 16; i++) wr(24'(32'h100 + i));
    check("fill_count", 32'(oCmdCount), 16);
    check("fill_full",  32'(oCmdFull), 1);
    check("fill_ovf",   32'(oOverflow), 0);
    wr(24'hDEAD00);
    check("ovf_set",   32'(oOverflow), 1);
    check("ovf_count", 32'(oCmdCount), 16);
    iClrErr = 1'b1;
    step();
    iClrErr = 1'b0;
    check("ovf_clr", 32'(oOverflow), 0);
    go(1'b0);
    for (int i = 0; i < 16; i++) cmd("drain", 24'(32'h100 + i));
    tail("drain");
    check("drain_count", 32'(oCmdCount), 0);

    // Write and iGo during ISSUE: entry joins this run, no second run.
    wr(24'hABCDEF);
    go(1'b0);
    seg("mid_e1_buf", 8'h01, 128, 1'b1, 24'hABCDEF);
    check("mid_issue_start", 32'(oControlComm), 2);
    iCmdData  = 24'h135790;
    iCmdWrite = 1'b1;
    iGo       = 1'b1;
    step();
    iCmdWrite = 1'b0;
    iGo       = 1'b0;
    check("mid_count", 32'(oCmdCount), 1);
    seg("mid_e1_issue", 8'h02, 1023, 1'b1, 24'hABCDEF);
    seg("mid_e1_gap",   8'h00, 128,  1'b0, 24'd0);
    cmd("mid_e2", 24'h135790);
    tail("mid");
    seg("mid_no_rerun", 8'h00, 200, 1'b0, 24'd0);
    check("mid_busy_after", 32'(oBusy), 0);

    // Reset during ISSUE aborts at once.
    wr(24'h0000AA);
    wr(24'h0000BB);
    go(1'b0);
    seg("abort_buf",   8'h01, 128, 1'b1, 24'h0000AA);
    seg("abort_issue", 8'h02, 10,  1'b1, 24'h0000AA);
    iStateReset = 1'b1;
    step();
    iStateReset = 1'b0;
    check("abort_comm",  32'(oControlComm), 0);
    check("abort_count", 32'(oCmdCount), 0);
    check("abort_busy",  32'(oBusy), 0);
    check("abort_done",  32'(oDone), 0);
    check("abort_ser",   32'(oSerialCmd), 0);
    seg("abort_quiet", 8'h00, 100, 1'b0, 24'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_cmd_sequencer.md
Name: adc_cmd_sequencer

Overview:
- Queues 24-bit ADC serial-interface register writes from the host and sequences the ADC control channel to deliver them.
- Emits the control codes (0xFF hardware reset, 0x00 idle, 0x01 buffer command, 0x02 issue command) in a fixed order.
- Holds each code long enough for the slow SCLK-domain controller to register the change and complete the 24-bit shift.
- Outputs drive the ADC control module's adc_control_comm and adc_serial_cmd inputs directly.

Parameters:
- FIFO_DEPTH, 16, command queue entries (power of two, 2..64)
- RESET_HOLD, 256, adc_clkinp cycles that 0xFF is held
- BUF_HOLD, 128, cycles that 0x01 is held (must cover ≥2 SCLK periods)
- ISSUE_HOLD, 1024, cycles that 0x02 is held (must cover ≥26 SCLK periods)
- GAP_HOLD, 128, cycles that 0x00 is held between codes

Ports:
- adc_clkinp  in  1  single clock
- iStateReset  in  1  synchronous, active-high reset
- iCmdData  in  24  command word to enqueue
- iCmdWrite  in  1  enqueue strobe, one entry per high cycle
- iGo  in  1  start draining the queue
- iHwReset  in  1  request a hardware-reset pulse before draining
- iClrErr  in  1  clears oOverflow
- oControlComm  out  8  control code to ADC control module
- oSerialCmd  out  24  command word to ADC control module
- oCmdCount  out  $clog2(FIFO_DEPTH)+1  entries queued
- oCmdFull  out  1  oCmdCount == FIFO_DEPTH
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle pulse at sequence completion
- oOverflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (iStateReset=1 at an adc_clkinp edge): state IDLE; oControlComm=0x00; oSerialCmd=0; FIFO flushed; oCmdCount=0; oCmdFull=0; oBusy=0; oDone=0; oOverflow=0; pending hw-reset flag=0. Reset mid-sequence aborts immediately with the same values. No further code is emitted.
- FIFO behaviour:
  - First-word fall-through. Write while full: data dropped, oOverflow<=1.
  - Write and pop in the same cycle: count unchanged, both take effect.
  - Write while count==0 and pop attempted: no pop occurs.
- iHwReset seen in any state sets the pending flag. iGo is accepted only in IDLE and ignored while busy.
- One down-counter loads on each state entry; a hold parameter of 0 is treated as 1.
- States:
  - IDLE: comm=0x00.
    - On iGo (or a pending flag with iGo): go to HWRST if the flag is set.
    - Else go to LOAD if count>0.
    - Else pulse oDone next cycle and stay in IDLE.
  - HWRST: comm=0xFF for RESET_HOLD cycles; clears the pending flag; then HWGAP.
  - HWGAP: comm=0x00 for GAP_HOLD; then LOAD if count>0, else FINISH.
  - LOAD: on entry, pop the head into oSerialCmd; comm=0x01 for BUF_HOLD; then ISSUE.
  - ISSUE: comm=0x02 for ISSUE_HOLD; oSerialCmd held stable; then GAP.
  - GAP: comm=0x00 for GAP_HOLD; then LOAD if count>0, else FINISH.
  - FINISH: oDone=1 for one cycle; go to IDLE.
- oSerialCmd changes only on LOAD entry and is stable through the full LOAD+ISSUE interval.
- Codes always alternate through 0x00 between commands. The downstream controller acts only on code changes, so back-to-back identical codes never occur.
- Entries written during draining are consumed in the same run if present when GAP ends.
- Per-command latency = BUF_HOLD+ISSUE_HOLD+GAP_HOLD cycles. The first LOAD follows iGo by 1 cycle (no hw reset).

Optional Feature:
- Macro: ADC_CMD_SEQ_AUTOSYNC_EN.
- Defined: a SYNC state is inserted before FINISH on every path that issued at least one command or reset. SYNC drives comm=0x04 for BUF_HOLD cycles, then comm=0x00 for GAP_HOLD cycles, then FINISH.
- Undefined: the SYNC state and its logic are absent; the path goes GAP/HWGAP→FINISH directly.

Test Plan:
- Reset behaviour: write 3 entries, assert iStateReset 1 cycle → count=0, comm=0x00, oBusy=0. A subsequent iGo gives an oDone pulse with no code ≠0x00 ever emitted.
- Single command: enqueue 0x0A1234, iGo, no hw reset.
  - Expected: comm sequence 0x01 (128 cycles), 0x02 (1024), 0x00 (128), then oDone. oSerialCmd=0x0A1234 throughout.
  - Run the real ADC controller with SCLK model: it shifts out 0x0A1234 MSB-first with SEN low for 24 SCLK.
- HW reset + 2 commands: iHwReset and iGo same cycle.
  - Expected: 0xFF for 256 cycles, 0x00 for 128, then both commands in FIFO order.
  - oDone asserts exactly once, at 256+128+2×1280+1 cycles after iGo.
- FIFO full/overflow: 17 writes with depth 16 → oCmdFull=1 after 16th, oOverflow=1, 17th dropped. iClrErr clears oOverflow; a drain issues exactly 16 words.
- Mid-run writes / iGo ignored: during ISSUE of entry 1, enqueue entry 2 and pulse iGo → entry 2 issued in the same run, no second run started, single oDone.
- Reset mid-ISSUE: assert iStateReset while comm=0x02 → next cycle comm=0x00, FIFO empty, no oDone. With ADC_CMD_SEQ_AUTOSYNC_EN, a normal run shows 0x04 for 128 cycles before oDone.
